// File: rtl/dmem_responder_pkg.sv
// Shared memory-protocol definitions used by the data-memory responder and the initiator-side LSU.
// Holds the access-size codes, the responder FSM state type and the address-window helper.
package mem_pkg;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] EXTA = 2'b11;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Evaluated in 33 bits so that a window ending exactly at 2^32 does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(words) << 2);
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store initiator and the data-memory responder.
interface dmem_responder_if;

  logic        reqValid;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [1:0]  size;
  logic        respValid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output reqValid, addr, wen, wdata, wmask, size,
    input  respValid, rdata, err
  );

  modport slave (
    input  reqValid, addr, wen, wdata, wmask, size,
    output respValid, rdata, err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module dmem_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wmask[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request at a time, answers exactly LATENCY
// cycles later, and flags (sticky) any request that arrives while an access is still pending.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  io,
  output logic             proto_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam bit          LAT1     = (LATENCY == 1);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_wen_q, resp_wen_d;
  logic        proto_err_q, proto_err_d;

  logic        enter_resp;
  logic [31:0] cur_addr;
  logic        cur_wen;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wmask;
  logic        cur_in_range;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic        unused_size;

  assign unused_size = ^io.size;

  // The store is touched on the edge entering RESP. With LATENCY=1 that edge is the acceptance
  // edge itself, so the live request is used instead of the latched copy.
  always_comb begin
    cur_addr     = LAT1 ? io.addr  : addr_q;
    cur_wen      = LAT1 ? io.wen   : wen_q;
    cur_wdata    = LAT1 ? io.wdata : wdata_q;
    cur_wmask    = LAT1 ? io.wmask : wmask_q;
    cur_in_range = addr_in_range(cur_addr, BASE_ADDR, DEPTH_WORDS);
    enter_resp   = LAT1 ? (io.reqValid && (state_q != WAIT))
                        : ((state_q == WAIT) && (cnt_q == 4'd1));
    ram_en       = enter_resp && cur_in_range && !reset;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    proto_err_d  = proto_err_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_wen_d   = 1'b0;

    unique case (state_q)
      IDLE, RESP: begin
        if (io.reqValid) begin
          addr_d  = io.addr;
          wen_d   = io.wen;
          wdata_d = io.wdata;
          wmask_d = io.wmask;
          cnt_d   = CNT_INIT;
          state_d = LAT1 ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (io.reqValid) begin
          proto_err_d = 1'b1;
        end
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !cur_in_range;
      resp_wen_d   = cur_wen;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_wen_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_wen_q   <= resp_wen_d;
      proto_err_q  <= proto_err_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock (clock),
    .en    (ram_en),
    .we    (cur_wen),
    .wmask (cur_wmask),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // Response selection uses only flops, so nothing from the inputs reaches the outputs.
  assign io.respValid = resp_valid_q;
  assign io.err       = resp_err_q;
  assign io.rdata     = !resp_valid_q ? '0
                      : resp_err_q    ? ERR_RDATA
                      : resp_wen_q    ? '0
                      : ram_rdata;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 2, 1, 4) with one shared stimulus stream and checks each
// against a cycle-level transaction model through per-instance expected-response queues.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int          NDUT  = 3;
  localparam int          NEVER = 32'h7fff_ffff;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] LIMIT = 32'h8000_1000;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    logic        undo;
    int          idx;
    logic [31:0] old;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic [1:0]  req_size = WORD;
  logic [NDUT-1:0] proto_err;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic mon_on = 1'b0;

  exp_t        exp_q [NDUT][$];
  logic [31:0] mem_m [NDUT][1024];
  int          free_at [NDUT];
  int          proto_at [NDUT];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder_if ifc();

    assign ifc.reqValid = req_valid;
    assign ifc.addr     = req_addr;
    assign ifc.wen      = req_wen;
    assign ifc.wdata    = req_wdata;
    assign ifc.wmask    = req_wmask;
    assign ifc.size     = req_size;

    dmem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h8000_0000),
      .LATENCY     ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .io        (ifc),
      .proto_err (proto_err[g])
    );

    always begin
      exp_t e;
      int   c;
      @(posedge clock);
      #1;
      c = cyc;
      if (mon_on) begin
        if (ifc.respValid === 1'b1) begin
          tests++;
          if (exp_q[g].size() == 0) begin
            fails++;
            $display("FAIL dut%0d unexpected_resp cycle=%0d got rdata=%h err=%b, required no response",
                     g, c, ifc.rdata, ifc.err);
          end else begin
            e = exp_q[g].pop_front();
            if (e.due != c || ifc.rdata !== e.rdata || ifc.err !== e.err) begin
              fails++;
              $display("FAIL dut%0d resp got cycle=%0d rdata=%h err=%b, required cycle=%0d rdata=%h err=%b",
                       g, c, ifc.rdata, ifc.err, e.due, e.rdata, e.err);
            end
          end
        end else begin
          tests++;
          if (ifc.respValid !== 1'b0 || ifc.rdata !== 32'h0 || ifc.err !== 1'b0) begin
            fails++;
            $display("FAIL dut%0d idle_outputs cycle=%0d got valid=%b rdata=%h err=%b, required 0/0/0",
                     g, c, ifc.respValid, ifc.rdata, ifc.err);
          end
          if (exp_q[g].size() > 0 && exp_q[g][0].due <= c) begin
            tests++;
            fails++;
            e = exp_q[g].pop_front();
            $display("FAIL dut%0d missing_resp cycle=%0d got no response, required rdata=%h err=%b at cycle %0d",
                     g, c, e.rdata, e.err, e.due);
          end
        end
        tests++;
        if (proto_err[g] !== (proto_at[g] <= c)) begin
          fails++;
          $display("FAIL dut%0d proto_err cycle=%0d got %b, required %b",
                   g, c, proto_err[g], (proto_at[g] <= c));
        end
      end
    end
  end

  // One clock cycle of stimulus plus the model's view of what each instance does with it.
  task automatic step(input logic rv, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] wm, input logic rst);
    exp_t e;
    int   t;
    int   idx;
    @(negedge clock);
    t         = cyc;
    reset     = rst;
    req_valid = rv;
    req_addr  = a;
    req_wen   = w;
    req_wdata = wd;
    req_wmask = wm;
    for (int g = 0; g < NDUT; g++) begin
      if (rst) begin
        while (exp_q[g].size() > 0 && exp_q[g][$].due > t) begin
          e = exp_q[g].pop_back();
          if (e.undo) mem_m[g][e.idx] = e.old;
        end
        free_at[g]  = t + 1;
        proto_at[g] = NEVER;
      end else if (rv) begin
        if (t >= free_at[g]) begin
          e.due  = t + lat_of(g);
          e.undo = 1'b0;
          e.idx  = 0;
          e.old  = '0;
          if (a < BASE || a >= LIMIT) begin
            e.rdata = 32'hDEAD_BEEF;
            e.err   = 1'b1;
          end else begin
            idx   = int'((a - BASE) >> 2);
            e.err = 1'b0;
            if (w) begin
              e.rdata = '0;
              e.undo  = 1'b1;
              e.idx   = idx;
              e.old   = mem_m[g][idx];
              for (int b = 0; b < 4; b++) begin
                if (wm[b]) mem_m[g][idx][8*b +: 8] = wd[8*b +: 8];
              end
            end else begin
              e.rdata = mem_m[g][idx];
            end
          end
          exp_q[g].push_back(e);
          free_at[g] = e.due;
        end else if (proto_at[g] == NEVER) begin
          proto_at[g] = t + 1;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] wm);
    step(1'b1, a, w, wd, wm, 1'b0);
    repeat (4) idle();
  endtask

  initial begin
    int          sel;
    int          gap;
    logic [31:0] a;
    for (int g = 0; g < NDUT; g++) begin
      free_at[g]  = 0;
      proto_at[g] = NEVER;
    end
    repeat (3) step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    mon_on = 1'b1;
    idle();

    for (int i = 0; i < 16; i++) req(BASE + 32'(i * 4), 1'b1, $urandom, 4'hF);

    req(32'h8000_0010, 1'b1, 32'h1122_3344, 4'hF);
    req(32'h8000_0010, 1'b0, '0, 4'h0);
    req(32'h8000_0010, 1'b1, 32'hAABB_CCDD, 4'b0110);
    req(32'h8000_0010, 1'b0, '0, 4'h0);
    req(32'h8000_0018, 1'b1, 32'hFFFF_FFFF, 4'b0000);
    req(32'h8000_0018, 1'b0, '0, 4'h0);

    step(1'b1, 32'h8000_0011, 1'b0, '0, 4'h0, 1'b0);
    idle();
    step(1'b1, 32'h8000_0014, 1'b0, '0, 4'h0, 1'b0);
    repeat (5) idle();

    req(32'h7FFF_FFFC, 1'b0, '0, 4'h0);
    req(32'h8000_1000, 1'b1, 32'h0BAD_F00D, 4'hF);
    req(32'h8000_0000, 1'b0, '0, 4'h0);

    for (int k = 0; k < 6; k++) begin
      step(1'b1, BASE + 32'((k % 4) * 4), 1'(k % 2), $urandom, 4'hF, 1'b0);
    end
    repeat (5) idle();

    step(1'b1, 32'h8000_0020, 1'b1, 32'h5555_AAAA, 4'hF, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle();
    req(32'h8000_0020, 1'b0, '0, 4'h0);

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 32'h7FFF_FFFC;
      else if (sel == 1) a = LIMIT + ($urandom_range(0, 15) << 2);
      else               a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      step(1'b1, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
      gap = int'($urandom_range(0, 4));
      repeat (gap) idle();
    end

    repeat (10) idle();
    for (int g = 0; g < NDUT; g++) begin
      tests++;
      if (exp_q[g].size() != 0) begin
        fails++;
        $display("FAIL dut%0d drain got %0d outstanding responses, required 0", g, exp_q[g].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
